filter_coeff_ctrl: RTL and testbench

FILTER_COEFF_CTRL -- requirements
Module: filter_coeff_ctrl

---
 rtl/filter_coeff_ctrl.sv | 136 +++++++++++++
 tb/tb_filter_coeff_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/filter_coeff_ctrl.sv
// Coefficient RAM arbiter: the filter read port has absolute priority over
// single-entry host write/read holders; also counts host-blocked cycles.
module filter_coeff_ctrl #(
    parameter int PTR   = 9,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             cfg_wr_rts,
    output logic             cfg_wr_rtr,
    input  logic [PTR-1:0]   cfg_wr_addr,
    input  logic [WIDTH-1:0] cfg_wr_data,
    input  logic             cfg_rd_rts,
    output logic             cfg_rd_rtr,
    input  logic [PTR-1:0]   cfg_rd_addr,
    output logic [WIDTH-1:0] cfg_rd_data,
    output logic             cfg_rd_valid,
    input  logic             mux_re,
    input  logic [PTR-1:0]   mux_rdptr,
    output logic [WIDTH-1:0] rf_filter_coeff,
    output logic             ram_we,
    output logic             ram_re,
    output logic [PTR-1:0]   ram_addr,
    output logic [WIDTH-1:0] ram_wdata,
    input  logic [WIDTH-1:0] ram_rdata,
    input  logic             trig_coeff_stall_clear,
    output logic [15:0]      ro_coeff_stall_cnt
);

    typedef enum logic {IDLE, RD_CAPTURE} state_t;

    state_t           state, state_nxt;
    logic             rdy_q;
    logic             wr_full, rd_full;
    logic [PTR-1:0]   wr_addr_q, rd_addr_q;
    logic [WIDTH-1:0] wr_data_q;
    logic             wr_commit, rd_issue, host_pending;

    // Ready lines stay low until the first edge after reset release.
    assign cfg_wr_rtr      = rdy_q & ~wr_full;
    assign cfg_rd_rtr      = rdy_q & ~rd_full;
    assign rf_filter_coeff = ram_rdata;
    assign ram_wdata       = wr_data_q;

    // A read counts as pending only until it has been issued to the RAM.
    assign host_pending = wr_full | (rd_full & (state == IDLE));

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:       if (rd_issue) state_nxt = RD_CAPTURE;
            RD_CAPTURE: state_nxt = IDLE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_comb begin
        wr_commit = 1'b0;
        rd_issue  = 1'b0;
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        ram_addr  = '0;
        if (mux_re) begin
            ram_re   = 1'b1;
            ram_addr = mux_rdptr;
        end else if (state == IDLE) begin
            if (wr_full) begin
                wr_commit = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = wr_addr_q;
            end else if (rd_full) begin
                rd_issue = 1'b1;
                ram_re   = 1'b1;
                ram_addr = rd_addr_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            rdy_q     <= 1'b0;
            wr_full   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            rdy_q <= 1'b1;
            if (wr_commit) begin
                wr_full <= 1'b0;
            end else if (cfg_wr_rts && cfg_wr_rtr) begin
                wr_full   <= 1'b1;
                wr_addr_q <= cfg_wr_addr;
                wr_data_q <= cfg_wr_data;
            end
        end
    end

    // Capture samples the RAM output of the issue cycle, so a filter read
    // landing in RD_CAPTURE cannot disturb it.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            rd_full      <= 1'b0;
            rd_addr_q    <= '0;
            cfg_rd_data  <= '0;
            cfg_rd_valid <= 1'b0;
        end else begin
            cfg_rd_valid <= 1'b0;
            if (state == RD_CAPTURE) begin
                rd_full      <= 1'b0;
                cfg_rd_data  <= ram_rdata;
                cfg_rd_valid <= 1'b1;
            end else if (cfg_rd_rts && cfg_rd_rtr) begin
                rd_full   <= 1'b1;
                rd_addr_q <= cfg_rd_addr;
            end
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            ro_coeff_stall_cnt <= '0;
        end else if (trig_coeff_stall_clear) begin
            ro_coeff_stall_cnt <= '0;
        end else if (mux_re && host_pending && (ro_coeff_stall_cnt != 16'hFFFF)) begin
            ro_coeff_stall_cnt <= ro_coeff_stall_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_filter_coeff_ctrl.sv
// Directed bench for filter_coeff_ctrl with a behavioural single-port RAM.
module tb_filter_coeff_ctrl;

    logic        clk = 1'b0;
    logic        rstb;
    logic        cfg_wr_rts, cfg_wr_rtr;
    logic [8:0]  cfg_wr_addr;
    logic [15:0] cfg_wr_data;
    logic        cfg_rd_rts, cfg_rd_rtr;
    logic [8:0]  cfg_rd_addr;
    logic [15:0] cfg_rd_data;
    logic        cfg_rd_valid;
    logic        mux_re;
    logic [8:0]  mux_rdptr;
    logic [15:0] rf_filter_coeff;
    logic        ram_we, ram_re;
    logic [8:0]  ram_addr;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata = '0;
    logic        trig_coeff_stall_clear;
    logic [15:0] ro_coeff_stall_cnt;

    logic [15:0] mem [512] = '{default: '0};

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    filter_coeff_ctrl #(.PTR(9), .WIDTH(16)) dut (
        .clk                    (clk),
        .rstb                   (rstb),
        .cfg_wr_rts             (cfg_wr_rts),
        .cfg_wr_rtr             (cfg_wr_rtr),
        .cfg_wr_addr            (cfg_wr_addr),
        .cfg_wr_data            (cfg_wr_data),
        .cfg_rd_rts             (cfg_rd_rts),
        .cfg_rd_rtr             (cfg_rd_rtr),
        .cfg_rd_addr            (cfg_rd_addr),
        .cfg_rd_data            (cfg_rd_data),
        .cfg_rd_valid           (cfg_rd_valid),
        .mux_re                 (mux_re),
        .mux_rdptr              (mux_rdptr),
        .rf_filter_coeff        (rf_filter_coeff),
        .ram_we                 (ram_we),
        .ram_re                 (ram_re),
        .ram_addr               (ram_addr),
        .ram_wdata              (ram_wdata),
        .ram_rdata              (ram_rdata),
        .trig_coeff_stall_clear (trig_coeff_stall_clear),
        .ro_coeff_stall_cnt     (ro_coeff_stall_cnt)
    );

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        if (ram_re) ram_rdata <= mem[ram_addr];
    end

    typedef struct {
        logic        wr;  logic [8:0] wa; logic [15:0] wd;
        logic        rd;  logic [8:0] ra;
        logic        mr;  logic [8:0] mp;
        logic        e_we; logic e_re; logic [8:0] e_addr; logic [15:0] e_wd;
        logic        e_wr_rtr; logic e_rd_rtr; logic e_valid; logic [15:0] e_data;
        logic [15:0] e_rf; logic [15:0] e_cnt;
    } vec_t;

    vec_t tbl [14];

    function automatic vec_t mk(input logic wr, input logic [8:0] wa, input logic [15:0] wd,
                                input logic rd, input logic [8:0] ra,
                                input logic mr, input logic [8:0] mp,
                                input logic ewe, input logic ere, input logic [8:0] ea,
                                input logic [15:0] ewd,
                                input logic ewr, input logic err, input logic ev,
                                input logic [15:0] ed, input logic [15:0] erf,
                                input logic [15:0] ec);
        vec_t v;
        v.wr = wr; v.wa = wa; v.wd = wd; v.rd = rd; v.ra = ra; v.mr = mr; v.mp = mp;
        v.e_we = ewe; v.e_re = ere; v.e_addr = ea; v.e_wd = ewd;
        v.e_wr_rtr = ewr; v.e_rd_rtr = err; v.e_valid = ev; v.e_data = ed;
        v.e_rf = erf; v.e_cnt = ec;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, " wr_rtr"}, 32'(cfg_wr_rtr), 0);
        chk({tag, " rd_rtr"}, 32'(cfg_rd_rtr), 0);
        chk({tag, " valid"},  32'(cfg_rd_valid), 0);
        chk({tag, " rd_data"}, 32'(cfg_rd_data), 0);
        chk({tag, " cnt"},    32'(ro_coeff_stall_cnt), 0);
        chk({tag, " we"},     32'(ram_we), 0);
    endtask

    initial begin
        rstb = 1'b0;
        cfg_wr_rts = 0; cfg_wr_addr = '0; cfg_wr_data = '0;
        cfg_rd_rts = 0; cfg_rd_addr = '0;
        mux_re = 0; mux_rdptr = '0; trig_coeff_stall_clear = 0;

        //          wr wa     wd        rd ra     mr mp     we re addr   wdata     wrr rdr v  rd_data   rf        cnt
        tbl[0]  = mk(0, 9'h0,  16'h0,    0, 9'h0,  0, 9'h0,  0, 0, 9'h0,  16'h0,    0, 0, 0, 16'h0,    16'h0,    0);
        tbl[1]  = mk(1, 9'h5,  16'h1234, 0, 9'h0,  0, 9'h0,  0, 0, 9'h0,  16'h0,    1, 1, 0, 16'h0,    16'h0,    0);
        tbl[2]  = mk(0, 9'h0,  16'h0,    0, 9'h0,  0, 9'h0,  1, 0, 9'h5,  16'h1234, 0, 1, 0, 16'h0,    16'h0,    0);
        tbl[3]  = mk(0, 9'h0,  16'h0,    1, 9'h5,  0, 9'h0,  0, 0, 9'h0,  16'h0,    1, 1, 0, 16'h0,    16'h0,    0);
        tbl[4]  = mk(0, 9'h0,  16'h0,    0, 9'h0,  0, 9'h0,  0, 1, 9'h5,  16'h0,    1, 0, 0, 16'h0,    16'h0,    0);
        tbl[5]  = mk(0, 9'h0,  16'h0,    0, 9'h0,  0, 9'h0,  0, 0, 9'h0,  16'h0,    1, 0, 0, 16'h0,    16'h1234, 0);
        tbl[6]  = mk(0, 9'h0,  16'h0,    0, 9'h0,  0, 9'h0,  0, 0, 9'h0,  16'h0,    1, 1, 1, 16'h1234, 16'h1234, 0);
        tbl[7]  = mk(0, 9'h0,  16'h0,    0, 9'h0,  0, 9'h0,  0, 0, 9'h0,  16'h0,    1, 1, 0, 16'h1234, 16'h1234, 0);
        tbl[8]  = mk(1, 9'h1FF,16'hBEEF, 1, 9'h1FF,1, 9'h5,  0, 1, 9'h5,  16'h0,    1, 1, 0, 16'h1234, 16'h1234, 0);
        tbl[9]  = mk(0, 9'h0,  16'h0,    0, 9'h0,  0, 9'h0,  1, 0, 9'h1FF,16'hBEEF, 0, 0, 0, 16'h1234, 16'h1234, 0);
        tbl[10] = mk(0, 9'h0,  16'h0,    0, 9'h0,  0, 9'h0,  0, 1, 9'h1FF,16'h0,    1, 0, 0, 16'h1234, 16'h1234, 0);
        tbl[11] = mk(0, 9'h0,  16'h0,    0, 9'h0,  1, 9'h5,  0, 1, 9'h5,  16'h0,    1, 0, 0, 16'h1234, 16'hBEEF, 0);
        tbl[12] = mk(0, 9'h0,  16'h0,    0, 9'h0,  0, 9'h0,  0, 0, 9'h0,  16'h0,    1, 1, 1, 16'hBEEF, 16'h1234, 0);
        tbl[13] = mk(1, 9'h0A, 16'h5A5A, 0, 9'h0,  1, 9'h0,  0, 1, 9'h0,  16'h0,    1, 1, 0, 16'hBEEF, 16'h1234, 0);

        repeat (3) @(negedge clk);
        #1 chk_reset_state("reset");

        @(negedge clk);
        rstb = 1'b1;
        for (int i = 0; i < 14; i++) begin
            if (i != 0) @(negedge clk);
            cfg_wr_rts = tbl[i].wr; cfg_wr_addr = tbl[i].wa; cfg_wr_data = tbl[i].wd;
            cfg_rd_rts = tbl[i].rd; cfg_rd_addr = tbl[i].ra;
            mux_re = tbl[i].mr; mux_rdptr = tbl[i].mp;
            #1;
            chk($sformatf("v%0d we", i),      32'(ram_we), 32'(tbl[i].e_we));
            chk($sformatf("v%0d re", i),      32'(ram_re), 32'(tbl[i].e_re));
            chk($sformatf("v%0d addr", i),    32'(ram_addr), 32'(tbl[i].e_addr));
            if (tbl[i].e_we) chk($sformatf("v%0d wdata", i), 32'(ram_wdata), 32'(tbl[i].e_wd));
            chk($sformatf("v%0d wr_rtr", i),  32'(cfg_wr_rtr), 32'(tbl[i].e_wr_rtr));
            chk($sformatf("v%0d rd_rtr", i),  32'(cfg_rd_rtr), 32'(tbl[i].e_rd_rtr));
            chk($sformatf("v%0d valid", i),   32'(cfg_rd_valid), 32'(tbl[i].e_valid));
            chk($sformatf("v%0d rd_data", i), 32'(cfg_rd_data), 32'(tbl[i].e_data));
            chk($sformatf("v%0d rf", i),      32'(rf_filter_coeff), 32'(tbl[i].e_rf));
            chk($sformatf("v%0d cnt", i),     32'(ro_coeff_stall_cnt), 32'(tbl[i].e_cnt));
        end

        // Write to 0x0A held off by a 512-cycle filter burst.
        for (int i = 0; i < 512; i++) begin
            @(negedge clk);
            cfg_wr_rts = 0; mux_re = 1; mux_rdptr = '0;
            #1 chk("burst we", 32'(ram_we), 0);
        end
        @(negedge clk);
        mux_re = 0;
        #1;
        chk("burst commit we", 32'(ram_we), 1);
        chk("burst commit addr", 32'(ram_addr), 32'h0A);
        chk("burst commit wdata", 32'(ram_wdata), 32'h5A5A);
        chk("burst cnt", 32'(ro_coeff_stall_cnt), 512);
        @(negedge clk);
        #1;
        chk("post burst we", 32'(ram_we), 0);
        chk("post burst wr_rtr", 32'(cfg_wr_rtr), 1);
        chk("post burst cnt", 32'(ro_coeff_stall_cnt), 512);

        // Saturation and clear under continued blocking.
        @(negedge clk);
        cfg_wr_rts = 1; cfg_wr_addr = 9'h44; cfg_wr_data = 16'h1111; mux_re = 1;
        #1 chk("sat accept rtr", 32'(cfg_wr_rtr), 1);
        @(negedge clk);
        cfg_wr_rts = 0;
        repeat (65023) @(posedge clk);
        @(negedge clk);
        #1 chk("sat reach", 32'(ro_coeff_stall_cnt), 32'hFFFF);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1 chk("sat hold", 32'(ro_coeff_stall_cnt), 32'hFFFF);
        trig_coeff_stall_clear = 1;
        @(negedge clk);
        trig_coeff_stall_clear = 0;
        #1 chk("clear wins", 32'(ro_coeff_stall_cnt), 0);
        @(negedge clk);
        #1 chk("count after clear", 32'(ro_coeff_stall_cnt), 1);
        mux_re = 0;
        #1;
        chk("sat commit we", 32'(ram_we), 1);
        chk("sat commit addr", 32'(ram_addr), 32'h44);

        // Reset with a write pending: the write must be dropped.
        @(negedge clk);
        cfg_wr_rts = 1; cfg_wr_addr = 9'h33; cfg_wr_data = 16'h7777; mux_re = 1;
        @(negedge clk);
        cfg_wr_rts = 0; mux_re = 0; rstb = 0;
        #1 chk_reset_state("midop reset");
        repeat (2) @(negedge clk);
        rstb = 1;
        for (int i = 0; i < 6; i++) begin
            #1 chk("after reset we", 32'(ram_we), 0);
            @(negedge clk);
        end
        chk("dropped write mem", 32'(mem[9'h033]), 0);
        chk("after reset wr_rtr", 32'(cfg_wr_rtr), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
